dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, byte-address width; array depth is 2^(ADDR_W-2) 32-bit words (256).
REQ-002 The block SHALL have parameter RD_INIT, default 32'h0, value driven on rsp_rdata for write acks and error responses.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state and the memory array.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  CPU presents a load/store request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDR_W  byte address, taken from the ALU result.
REQ-010 req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 req_wdata  input  32  store data, taken from rd2; LSBs aligned.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  CPU accepts the response.
REQ-014 rsp_rdata  output  32  load data, extended to 32 bits.
REQ-015 rsp_err  output  1  misaligned access or illegal funct3.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge with state IDLE and req_valid=1; all request fields SHALL be latched at acceptance.
REQ-018 Error condition: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; funct3 other than 000/001/010 with req_we=1.
REQ-019 An error request SHALL NOT modify the array and SHALL go IDLE->RESP; rsp_err=1 and rsp_rdata=RD_INIT; rsp_valid rises 1 cycle after acceptance.
REQ-020 A legal store SHALL write the array at the acceptance edge, using byte enables from funct3 and addr[1:0]. SB writes wdata[7:0] into lane addr[1:0]. SH writes wdata[15:0] into lanes {addr[1],0},{addr[1],1}. SW writes all lanes.
REQ-021 A legal store SHALL go IDLE->RESP; rsp_valid rises 1 cycle after acceptance with rsp_err=0 and rsp_rdata=RD_INIT.
REQ-022 A legal load SHALL go IDLE->ACCESS->RESP; the array is read synchronously in ACCESS; rsp_valid rises 2 cycles after acceptance.
REQ-023 Load extraction: B/BU select byte addr[1:0]; H/HU select halfword addr[1]; B/H sign-extend; BU/HU zero-extend; W passes the word unchanged.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until a rising edge with rsp_ready=1; the FSM then enters IDLE and rsp_valid falls.
REQ-025 rsp_valid SHALL be 0 in IDLE and ACCESS; rsp_ready SHALL be ignored outside RESP.
REQ-026 req_valid SHALL be ignored outside IDLE; no request is queued.
REQ-027 Minimum spacing between accepted requests SHALL be 2 cycles for a store and 3 cycles for a load.
REQ-028 A load following a store to the same word SHALL return the newly written data.
REQ-029 Word index SHALL be addr[ADDR_W-1:2]; address wrap above the array is impossible by construction.

Reset
REQ-030 While rst_n=0: state=IDLE, rsp_valid=0, rsp_rdata=32'h0, rsp_err=0, req_ready=1, and no array write occurs.
REQ-031 rst_n assertion mid-operation (ACCESS or RESP) SHALL abort the transaction immediately. Any store already committed at its acceptance edge SHALL remain.
REQ-032 Array contents SHALL NOT be cleared by reset.

Verification
REQ-033 SW addr 0x10 data 0x8899AABB, then LW 0x10 -> ack after 1 cycle with err=0; load rdata=0x8899AABB 2 cycles after acceptance.
REQ-034 After REQ-033: LB 0x13 -> 0xFFFFFF88; LBU 0x12 -> 0x00000099; LH 0x10 -> 0xFFFFAABB; LHU 0x12 -> 0x00008899.
REQ-035 SB addr 0x11 data 0x00000055 over 0x8899AABB, then LW 0x10 -> 0x889955BB.
REQ-036 LW addr 0x12 -> rsp_err=1, rdata=RD_INIT, and the array is unchanged. SH 0x13 -> rsp_err=1 and no write occurs.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP with req_valid=1 -> rsp_valid, rdata and err stay stable and req_ready=0; raising rsp_ready lets the next request be accepted 1 cycle later.
REQ-038 Assert rst_n=0 in ACCESS of a load -> rsp_valid=0 and state IDLE on release; a subsequent LW of a previously stored word returns the stored value.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for a RISC-V core: byte/half/word loads and stores
// against a 32-bit word array, with a valid/ready request and response handshake.
module dmem_responder #(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] RD_INIT = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  function automatic logic f_req_err(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic err;
    case (f3)
      3'b000:  err = 1'b0;
      3'b001:  err = lo[0];
      3'b010:  err = (lo != 2'b00);
      3'b100:  err = we;
      3'b101:  err = we | lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] f_byte_en(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << lo;
      3'b001:  be = lo[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the store data so the enabled lanes see the right bytes.
  function automatic logic [31:0] f_store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] lanes;
    case (f3)
      3'b000:  lanes = {4{wd[7:0]}};
      3'b001:  lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] f_load_extract(input logic [31:0] word,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'h0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic [IDX_W-1:0]  r_idx;
  logic [2:0]        r_funct3;
  logic [1:0]        r_lo;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_accept;
  logic              w_err;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_lanes;
  logic              w_req_ready;
  logic              w_rsp_valid;

  assign w_accept      = (r_state == S_IDLE) & req_valid;
  assign w_err         = f_req_err(req_we, req_funct3, req_addr[1:0]);
  assign w_idx         = req_addr[ADDR_W-1:2];
  assign w_be          = f_byte_en(req_funct3, req_addr[1:0]);
  assign w_wdata_lanes = f_store_lanes(req_funct3, req_wdata);
  // rst_n gates the write so a request presented during reset never lands.
  assign w_wr_en       = w_accept & req_we & ~w_err & rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: loads take an extra ACCESS cycle for the array read.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = (w_err | req_we) ? S_RESP : S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE:   w_req_ready = 1'b1;
      S_ACCESS: w_rsp_valid = 1'b0;
      S_RESP:   w_rsp_valid = 1'b1;
      default: begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
      end
    endcase
  end

  // Byte-lane writes into the word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
        end
      end
    end
  end

  // Request latch and response data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_funct3    <= 3'b000;
      r_lo        <= 2'b00;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_idx    <= w_idx;
            r_funct3 <= req_funct3;
            r_lo     <= req_addr[1:0];
            if (w_err | req_we) begin
              r_rsp_rdata <= RD_INIT;
              r_rsp_err   <= w_err;
            end
          end
        end
        S_ACCESS: begin
          r_rsp_rdata <= f_load_extract(r_mem[r_idx], r_funct3, r_lo);
          r_rsp_err   <= 1'b0;
        end
        default: begin
          r_rsp_rdata <= r_rsp_rdata;
          r_rsp_err   <= r_rsp_err;
        end
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
